// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S microphone receiver.
package i2s_pkg;
    localparam int SLOT_W      = 32;
    localparam int FRAME_BITS  = 64;
    localparam int BITCNT_W    = $clog2(FRAME_BITS);
    localparam int CLK_DIV_MIN = 3;

    typedef enum logic {
        I2S_LEFT  = 1'b0,
        I2S_RIGHT = 1'b1
    } i2s_chan_e;
endpackage

// File: rtl/i2s_full_sync_dff_module.sv
// Single synchronizer stage; two in series form the sd_i synchronizer.
module i2s_full_sync_dff_module (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);
    logic data_q;
    logic data_d;

    always_comb begin
        data_d = data_q;
        if (rst_i) begin
            data_d = 1'b0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign q_o = data_q;
endmodule

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider, frame bit counter and word select for the I2S master.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    output logic                sck_o,
    output logic                ws_o,
    output logic                capture_o,
    output logic                fall_o,
    output logic [BITCNT_W-1:0] bitcnt_o
);
    logic [7:0]          div_q, div_d;
    logic                sck_q, sck_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic                last_div;

    assign last_div = (div_q == 8'(CLK_DIV - 1));

    always_comb begin
        div_d    = div_q;
        sck_d    = sck_q;
        bitcnt_d = bitcnt_q;
        if (!en_i) begin
            div_d    = '0;
            sck_d    = 1'b0;
            bitcnt_d = '0;
        end else if (last_div) begin
            div_d = '0;
            sck_d = ~sck_q;
            if (sck_q) begin
                bitcnt_d = bitcnt_q + BITCNT_W'(1);
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            sck_q    <= 1'b0;
            bitcnt_q <= '0;
        end else begin
            div_q    <= div_d;
            sck_q    <= sck_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // The last high-phase cycle both samples data and launches the falling edge.
    assign capture_o = en_i && sck_q && last_div;
    assign fall_o    = en_i && sck_q && last_div;
    assign sck_o     = sck_q;
    assign ws_o      = bitcnt_q[BITCNT_W-1];
    assign bitcnt_o  = bitcnt_q;
endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver: deserializes one channel of a MEMS mic into a
// signed sample handed off over valid/ready with a sticky overrun flag.
module i2s_mic_rx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 24,
    parameter int CHANNEL  = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                sd_i,
    output logic                sck_o,
    output logic                ws_o,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overrun_o,
    input  logic                clr_ovr_i
);
    localparam i2s_chan_e  SLOT     = (CHANNEL != 0) ? I2S_RIGHT : I2S_LEFT;
    localparam logic [4:0] LAST_POS = 5'(SAMPLE_W);

    logic                sd_meta, sd_sync;
    logic                capture, fall;
    logic [BITCNT_W-1:0] bitcnt;
    logic [4:0]          slot_pos;
    logic                in_slot, in_window, load, accept;

    logic signed [SAMPLE_W-1:0] shift_q, shift_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic                       ovr_q, ovr_d;

    i2s_full_sync_dff_module u_sync0 (
        .clk_i (clk_i), .rst_i (1'b0), .en_i (1'b1), .d_i (sd_i),    .q_o (sd_meta)
    );
    i2s_full_sync_dff_module u_sync1 (
        .clk_i (clk_i), .rst_i (1'b0), .en_i (1'b1), .d_i (sd_meta), .q_o (sd_sync)
    );

    i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .sck_o     (sck_o),
        .ws_o      (ws_o),
        .capture_o (capture),
        .fall_o    (fall),
        .bitcnt_o  (bitcnt)
    );

    // Slot position 0 is the one-bit delay after WS changes; MSB arrives at 1.
    assign slot_pos  = bitcnt[4:0];
    assign in_slot   = (bitcnt[BITCNT_W-1] == logic'(SLOT));
    assign in_window = in_slot && (slot_pos != 5'd0) && (slot_pos <= LAST_POS);
    assign load      = fall && in_slot && (slot_pos == LAST_POS);
    assign accept    = valid_q && ready_i;

    always_comb begin
        shift_d  = shift_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (!en_i) begin
            shift_d = '0;
        end else if (capture && in_window) begin
            shift_d = (shift_q << 1) | SAMPLE_W'(sd_sync);
        end
        if (load) begin
            sample_d = shift_d;
            valid_d  = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
        if (load && valid_q && !ready_i) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample_o  = sample_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx with a behavioural I2S microphone.
module tb_i2s_mic_rx;
    localparam int CLK_DIV  = 4;
    localparam int SAMPLE_W = 24;

    logic clk = 1'b0;
    logic rst_ni, en_i, sd_i, ready_i, clr_ovr_i;
    logic sck0, ws0, valid0, ovr0;
    logic sck1, ws1, valid1, ovr1;
    logic [SAMPLE_W-1:0] sample0, sample1;

    logic [23:0] mic_left, mic_right;
    logic [5:0]  mic_cnt = 6'd0;
    logic        mic_prev = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    i2s_mic_rx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W), .CHANNEL(0)) dut0 (
        .clk_i (clk), .rst_ni (rst_ni), .en_i (en_i), .sd_i (sd_i),
        .sck_o (sck0), .ws_o (ws0), .sample_o (sample0), .valid_o (valid0),
        .ready_i (ready_i), .overrun_o (ovr0), .clr_ovr_i (clr_ovr_i)
    );

    i2s_mic_rx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SAMPLE_W), .CHANNEL(1)) dut1 (
        .clk_i (clk), .rst_ni (rst_ni), .en_i (en_i), .sd_i (sd_i),
        .sck_o (sck1), .ws_o (ws1), .sample_o (sample1), .valid_o (valid1),
        .ready_i (ready_i), .overrun_o (ovr1), .clr_ovr_i (clr_ovr_i)
    );

    always #5 clk = ~clk;

    // Microphone: advances its bit position on each SCK falling edge.
    always @(negedge clk) begin
        if (!rst_ni || !en_i) begin
            mic_cnt  <= 6'd0;
            mic_prev <= 1'b0;
        end else begin
            if (mic_prev && !sck0) mic_cnt <= mic_cnt + 6'd1;
            mic_prev <= sck0;
        end
    end

    function automatic logic mic_bit(input logic [5:0] c, input logic [23:0] l, input logic [23:0] r);
        logic [4:0]  pos;
        logic [23:0] w;
        pos = c[4:0];
        w   = c[5] ? r : l;
        if (pos == 5'd0 || pos > 5'd24) return 1'b0;
        return w[24 - pos];
    endfunction

    assign sd_i = mic_bit(mic_cnt, mic_left, mic_right);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid0(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (valid0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit   ok;
        int   n, hi, rises;
        logic pw, ps;

        rst_ni = 1'b0; en_i = 1'b0; ready_i = 1'b1; clr_ovr_i = 1'b0;
        mic_left = 24'hA5F00F; mic_right = 24'h123456;
        repeat (3) tick();
        chk("rst_sck",     sck0,    0);
        chk("rst_ws",      ws0,     0);
        chk("rst_sample",  sample0, 0);
        chk("rst_valid",   valid0,  0);
        chk("rst_ovr",     ovr0,    0);
        chk("rst_dut1",    {sck1, ws1, valid1, ovr1}, 0);

        // Left channel streaming with ready held high
        rst_ni = 1'b1; en_i = 1'b1;
        wait_valid0(700, ok);
        chk("left_seen", ok, 1);
        chk("left_sample", sample0, 32'hA5F00F);
        tick();
        chk("valid_pulse", valid0, 0);
        n = 1; ok = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick(); n++;
            if (valid0) begin ok = 1'b1; break; end
        end
        chk("period_seen", ok, 1);
        chk("frame_period", n, 512);
        chk("left_sample_2", sample0, 32'hA5F00F);

        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (valid1) begin ok = 1'b1; break; end
        end
        chk("right_seen", ok, 1);
        chk("right_sample", sample1, 32'h123456);

        // WS half-frame interval and SCK rises per frame
        pw = ws0;
        for (int i = 0; i < 300; i++) begin tick(); if (ws0 != pw) break; end
        pw = ws0; n = 0;
        for (int i = 0; i < 300; i++) begin tick(); n++; if (ws0 != pw) break; end
        chk("ws_half_frame", n, 256);
        pw = ws0;
        for (int i = 0; i < 600; i++) begin tick(); if (!pw && ws0) break; pw = ws0; end
        rises = 0; ps = sck0; pw = ws0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (!ps && sck0) rises++;
            ps = sck0;
            if (!pw && ws0) break;
            pw = ws0;
        end
        chk("sck_per_frame", rises, 64);

        // Overrun: two loads without consumption
        wait_valid0(600, ok);
        tick();
        ready_i = 1'b0; mic_left = 24'h000001;
        wait_valid0(600, ok);
        chk("ovr_first_seen", ok, 1);
        chk("ovr_first_sample", sample0, 32'h000001);
        chk("ovr_not_yet", ovr0, 0);
        mic_left = 24'h7FFFFF;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (sample0 != 24'h000001) begin ok = 1'b1; break; end
        end
        chk("ovr_second_seen", ok, 1);
        chk("ovr_sample", sample0, 32'h7FFFFF);
        chk("ovr_set", ovr0, 1);
        chk("ovr_valid", valid0, 1);
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
        chk("ovr_cleared", ovr0, 0);

        // Ready asserted exactly in the load cycle
        mic_left = 24'h5A5A5A;
        hi = 0; ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            hi = sck0 ? hi + 1 : 0;
            if (hi == CLK_DIV && mic_cnt == 6'd24 && !ws0) begin ok = 1'b1; break; end
        end
        chk("load_cycle_found", ok, 1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("same_cycle_valid", valid0, 1);
        chk("same_cycle_sample", sample0, 32'h5A5A5A);
        chk("same_cycle_ovr", ovr0, 0);

        // Disable at bit 10 while a sample is pending
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (mic_cnt == 6'd10 && sck0) begin ok = 1'b1; break; end
        end
        chk("bit10_found", ok, 1);
        en_i = 1'b0;
        tick();
        chk("dis_sck", sck0, 0);
        chk("dis_ws", ws0, 0);
        chk("dis_sample", sample0, 32'h5A5A5A);
        chk("dis_valid", valid0, 1);
        repeat (5) tick();
        chk("dis_sck_idle", sck0, 0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("dis_accept", valid0, 0);
        mic_left = 24'h3C3C3C; en_i = 1'b1;
        wait_valid0(700, ok);
        chk("reen_seen", ok, 1);
        chk("reen_sample", sample0, 32'h3C3C3C);

        // Async reset in the high phase of the right slot
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (ws0 && sck0) begin ok = 1'b1; break; end
        end
        chk("rst_point_found", ok, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_sck", sck0, 0);
        chk("arst_ws", ws0, 0);
        chk("arst_sample", sample0, 0);
        chk("arst_valid", valid0, 0);
        chk("arst_ovr", ovr0, 0);
        repeat (2) tick();
        rst_ni = 1'b1; mic_left = 24'h0F1E2D; ready_i = 1'b1;
        wait_valid0(700, ok);
        chk("post_rst_seen", ok, 1);
        chk("post_rst_sample", sample0, 32'h0F1E2D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
